apb3_master: RTL

APB3_MASTER -- requirements
Module: apb3_master

---
 rtl/apb3_master.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/apb3_master.sv
// APB3 requester: single-outstanding command/response front end driving an
// APB3 bus through the IDLE -> SETUP -> ACCESS sequence.
// Optional feature macro: APB3_MASTER_TIMEOUT_EN adds an ACCESS wait limit
// of TIMEOUT_CYCLES stalled cycles, after which the transfer is aborted and
// reported with rsp_error=1 and rsp_timeout=1.
module apb3_master #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   // request channel
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   // response channel
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic                  rsp_timeout,
   // APB3 requester side
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PSLVERROR,
   // status
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_accept;
   logic                  w_done;
   logic                  w_timeout_hit;

   logic [ADDR_WIDTH-1:0] r_paddr;
   logic                  r_pwrite;
   logic [DATA_WIDTH-1:0] r_pwdata;

   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_error;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("apb3_master: TIMEOUT_CYCLES must lie in 1..65535");
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic and state-decoded outputs
   always_comb begin
      w_state_nxt = r_state;
      cmd_ready   = 1'b0;
      PSEL        = 1'b0;
      PENABLE     = 1'b0;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = SETUP;
            end
         end
         SETUP: begin
            PSEL        = 1'b1;
            w_state_nxt = ACCESS;
         end
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
            // PREADY wins over a timeout reached on the same cycle
            if (PREADY) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end else if (w_timeout_hit) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign busy = (r_state != IDLE);

   // Latch the command on acceptance; held until the next accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_paddr  <= '0;
         r_pwrite <= 1'b0;
         r_pwdata <= '0;
      end else if (w_accept) begin
         r_paddr  <= cmd_addr;
         r_pwrite <= cmd_write;
         r_pwdata <= cmd_wdata;
      end
   end

   assign PADDR  = r_paddr;
   assign PWRITE = r_pwrite;
   assign PWDATA = r_pwdata;

`ifdef APB3_MASTER_TIMEOUT_EN
   localparam logic [15:0] LP_TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] r_to_cnt;
   logic        r_rsp_timeout;

   // The limit is hit on the stalled ACCESS cycle that makes the count reach
   // TIMEOUT_CYCLES, so the abort lands on that cycle's closing edge.
   assign w_timeout_hit = (r_state == ACCESS) && !PREADY && (r_to_cnt == LP_TO_LAST);

   // Count stalled ACCESS cycles; restart on every new transfer
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                              r_to_cnt <= '0;
      else if (w_accept)                      r_to_cnt <= '0;
      else if (r_state == ACCESS && !PREADY)  r_to_cnt <= r_to_cnt + 16'd1;
   end

   // Timeout flag of the most recent response
   always_ff @(posedge clk or posedge reset) begin
      if (reset)              r_rsp_timeout <= 1'b0;
      else if (w_done)        r_rsp_timeout <= 1'b0;
      else if (w_timeout_hit) r_rsp_timeout <= 1'b1;
   end

   assign rsp_timeout = r_rsp_timeout;
`else
   assign w_timeout_hit = 1'b0;
   assign rsp_timeout   = 1'b0;
`endif

   // Response capture: one-cycle valid pulse on completion or abort
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_error <= 1'b0;
      end else begin
         r_rsp_valid <= w_done || w_timeout_hit;
         if (w_done) begin
            if (!r_pwrite) r_rsp_rdata <= PRDATA;
            r_rsp_error <= PSLVERROR;
         end else if (w_timeout_hit) begin
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b1;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_error = r_rsp_error;

endmodule
